multicycle_core: RTL and testbench

//  Parametrised multicycle MIPS-subset core; successor to the single-cycle datapath top.

---
 rtl/core_pkg.sv | 56 +++++
 rtl/core_regfile.sv | 44 ++++
 rtl/multicycle_core.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs,
// ALU operation codes, FSM state codes and small decode helpers.
package core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    // True when the opcode (and funct for R-type) is one the core executes.
    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU operation for an instruction; address and immediate forms all add.
    function automatic alu_op_e alu_sel(input logic [5:0] op, input logic [5:0] funct);
        if (op != OP_RTYPE) return ALU_ADD;
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two operand read ports, one debug read port, one write
// port. r0 always reads zero and ignores writes.
module core_regfile
    import core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0]     ra_data,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]     rb_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int NREGS = 1 << REG_ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

    // Next register contents: apply the single write port, keep r0 at zero.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0))
            regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core. One instruction walks FETCH/DECODE/EXEC
// and optionally MEM/WB over external synchronous ROM/RAM with one-cycle
// read latency. Supports free-run and single-step, halts on illegal opcodes.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_mode,
    input  logic                  step,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic                  dmem_we,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  halted,
    input  logic [REG_ADDR_W-1:0] dbg_reg_sel,
    output logic [DATA_W-1:0]     dbg_reg_data,
    output logic [PC_W-1:0]       dbg_pc,
    output logic [2:0]            dbg_state
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                halted_q, halted_d;
    logic                step_prev_q, step_prev_d;
    logic                pending_q, pending_d;

    // Fields of the instruction arriving from the ROM (used in DECODE).
    logic [5:0]            op_in, fn_in;
    logic [REG_ADDR_W-1:0] rs_in, rt_in;
    assign op_in = imem_rdata[31:26];
    assign fn_in = imem_rdata[5:0];
    assign rs_in = imem_rdata[21 +: REG_ADDR_W];
    assign rt_in = imem_rdata[16 +: REG_ADDR_W];

    // Fields of the latched instruction (used in EXEC/MEM/WB).
    logic [5:0]            op_ir, fn_ir;
    logic [REG_ADDR_W-1:0] rt_ir, rd_ir;
    logic [DATA_W-1:0]     imm_data;
    logic [PC_W-1:0]       imm_pc;
    assign op_ir    = ir_q[31:26];
    assign fn_ir    = ir_q[5:0];
    assign rt_ir    = ir_q[16 +: REG_ADDR_W];
    assign rd_ir    = ir_q[11 +: REG_ADDR_W];
    assign imm_data = DATA_W'($signed(ir_q[15:0]));
    assign imm_pc   = PC_W'($signed(ir_q[15:0]));

    // Encoding bits the subset ignores (shamt, truncated register bits).
    logic unused_bits;
    assign unused_bits = ^{ir_q, imem_rdata};

    logic [DATA_W-1:0]     ra_data, rb_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  step_rise;

    assign step_rise = step & ~step_prev_q;
    assign rf_waddr  = (op_ir == OP_RTYPE) ? rd_ir : rt_ir;

    core_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (rs_in),
        .ra_data  (ra_data),
        .rb_addr  (rt_in),
        .rb_data  (rb_data),
        .dbg_addr (dbg_reg_sel),
        .dbg_data (dbg_reg_data),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;

    assign alu_op = alu_sel(op_ir, fn_ir);
    assign alu_b  = (op_ir == OP_RTYPE) ? b_q : imm_data;

    // ALU: second operand is B for R-type, sign-extended immediate otherwise.
    always_comb begin
        alu_res = a_q + alu_b;
        case (alu_op)
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = ($signed(a_q) < $signed(alu_b)) ? DATA_W'(1) : '0;
            default: ;
        endcase
    end

    // Next-state and datapath updates for the instruction sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        halted_d    = halted_q;
        step_prev_d = step;
        pending_d   = pending_q | step_rise;
        rf_we       = 1'b0;
        rf_wdata    = alu_q;
        dmem_we     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Leaving FETCH consumes the pending step; an edge seen in
                // this same cycle is kept for the next instruction.
                if (run_mode || pending_q) begin
                    state_d   = ST_DECODE;
                    pending_d = step_rise;
                end
            end
            ST_DECODE: begin
                ir_d = imem_rdata;
                a_d  = ra_data;
                b_d  = rb_data;
                pc_d = pc_q + 1'b1;
                if (instr_legal(op_in, fn_in)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_EXEC: begin
                alu_d = alu_res;
                case (op_ir)
                    OP_BEQ: begin
                        // PC already points past the branch.
                        if (a_q == b_q) pc_d = pc_q + imm_pc;
                        state_d = ST_FETCH;
                    end
                    OP_J: begin
                        pc_d    = ir_q[PC_W-1:0];
                        state_d = ST_FETCH;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (op_ir == OP_SW) begin
                    dmem_we = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_wdata = (op_ir == OP_LW) ? dmem_rdata : alu_q;
                state_d  = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Sequencer and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            halted_q    <= 1'b0;
            step_prev_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            halted_q    <= halted_d;
            step_prev_q <= step_prev_d;
            pending_q   <= pending_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign halted     = halted_q;
    assign dbg_pc     = pc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a bench ROM, a bench
// RAM, and hand-computed register/PC/state values at fixed cycle counts.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_mode = 1'b1;
    logic        step = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_we;
    logic [7:0]  dmem_rdata = '0;
    logic        halted;
    logic [2:0]  dbg_reg_sel = '0;
    logic [7:0]  dbg_reg_data;
    logic [7:0]  dbg_pc;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [31:0] rom [0:255];
    logic [7:0]  ram [0:255];

    int         we_cnt = 0;
    logic [7:0] we_addr = '0;
    logic [7:0] we_data = '0;

    multicycle_core #(.DATA_W(8), .PC_W(8), .REG_ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_mode     (run_mode),
        .step         (step),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .dmem_rdata   (dmem_rdata),
        .halted       (halted),
        .dbg_reg_sel  (dbg_reg_sel),
        .dbg_reg_data (dbg_reg_data),
        .dbg_pc       (dbg_pc),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous ROM/RAM, one-cycle read latency.
    always @(posedge clk) begin
        imem_rdata <= rom[imem_addr];
        dmem_rdata <= ram[dmem_addr];
        if (dmem_we === 1'b1) ram[dmem_addr] <= dmem_wdata;
    end

    // Store-strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (dmem_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= dmem_addr;
            we_data <= dmem_wdata;
        end
    end

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] tgt);
        return {6'b000010, tgt};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    task automatic do_reset(input logic rm);
        rst = 1'b1;
        step = 1'b0;
        run_mode = rm;
        for (int i = 0; i < 256; i++) ram[i] = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        dbg_reg_sel = 3'(idx);
        #1;
        v = dbg_reg_data;
    endtask

    task automatic step_pulse();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rst = 1'b1;
        run_mode = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (dbg_pc !== 8'h00) begin fails++; $display("FAIL reset_pc got %h exp 00", dbg_pc); end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
        tests++; if (dmem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", dmem_we); end
        rd(1, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_r1 got %h exp 00", v); end
    endtask

    task automatic test_add_seq();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rom[1] = enc_i(6'b001000, 0, 2, 16'd3);
        rom[2] = enc_r(1, 2, 3, 6'b100000);
        do_reset(1'b1);
        run(11);
        rd(3, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL add_early_r3 got %h exp 00", v); end
        run(1);
        rd(3, v);
        tests++; if (v !== 8'h08) begin fails++; $display("FAIL add_r3 got %h exp 08", v); end
        tests++; if (dbg_pc !== 8'h03) begin fails++; $display("FAIL add_pc got %h exp 03", dbg_pc); end
        rd(1, v);
        tests++; if (v !== 8'h05) begin fails++; $display("FAIL add_r1 got %h exp 05", v); end
    endtask

    task automatic test_alu_ops();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rom[1] = enc_i(6'b001000, 0, 2, 16'd3);
        rom[2] = enc_r(2, 1, 4, 6'b100010);
        rom[3] = enc_r(4, 1, 5, 6'b101010);
        rom[4] = enc_r(1, 2, 6, 6'b100100);
        rom[5] = enc_r(1, 2, 7, 6'b100101);
        do_reset(1'b1);
        run(24);
        rd(4, v);
        tests++; if (v !== 8'hFE) begin fails++; $display("FAIL sub_r4 got %h exp fe", v); end
        rd(5, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL slt_r5 got %h exp 01", v); end
        rd(6, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL and_r6 got %h exp 01", v); end
        rd(7, v);
        tests++; if (v !== 8'h07) begin fails++; $display("FAIL or_r7 got %h exp 07", v); end
    endtask

    task automatic test_load_store();
        logic [7:0] v;
        int snap;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rom[1] = enc_i(6'b001000, 0, 2, 16'd3);
        rom[2] = enc_r(1, 2, 3, 6'b100000);
        rom[3] = enc_i(6'b101011, 0, 3, 16'd2);
        rom[4] = enc_i(6'b100011, 0, 6, 16'd2);
        do_reset(1'b1);
        snap = we_cnt;
        run(20);
        rd(6, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL lw_early_r6 got %h exp 00", v); end
        run(1);
        rd(6, v);
        tests++; if (v !== 8'h08) begin fails++; $display("FAIL lw_r6 got %h exp 08", v); end
        tests++; if (we_cnt - snap !== 1) begin fails++; $display("FAIL sw_we_cycles got %0d exp 1", we_cnt - snap); end
        tests++; if (we_addr !== 8'h02) begin fails++; $display("FAIL sw_addr got %h exp 02", we_addr); end
        tests++; if (we_data !== 8'h08) begin fails++; $display("FAIL sw_wdata got %h exp 08", we_data); end
        tests++; if (ram[2] !== 8'h08) begin fails++; $display("FAIL sw_ram got %h exp 08", ram[2]); end
    endtask

    task automatic test_branch_jump();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rom[1] = enc_i(6'b000100, 1, 1, 16'hFFFF);
        do_reset(1'b1);
        run(4);
        tests++; if (dbg_pc !== 8'h01) begin fails++; $display("FAIL loop_pc0 got %h exp 01", dbg_pc); end
        run(2);
        tests++; if (dbg_pc !== 8'h02 || dbg_state !== 3'd2) begin fails++; $display("FAIL loop_mid got pc %h st %0d exp pc 02 st 2", dbg_pc, dbg_state); end
        run(1);
        tests++; if (dbg_pc !== 8'h01 || dbg_state !== 3'd0) begin fails++; $display("FAIL loop_iter got pc %h st %0d exp pc 01 st 0", dbg_pc, dbg_state); end
        run(6);
        tests++; if (dbg_pc !== 8'h01 || dbg_state !== 3'd0) begin fails++; $display("FAIL loop_iter3 got pc %h st %0d exp pc 01 st 0", dbg_pc, dbg_state); end

        clear_rom();
        rom[0]  = enc_i(6'b000100, 0, 0, 16'd2);
        rom[3]  = enc_j(26'h10);
        rom[16] = enc_i(6'b001000, 0, 1, 16'd7);
        rom[17] = enc_i(6'b000100, 1, 0, 16'd5);
        do_reset(1'b1);
        run(3);
        tests++; if (dbg_pc !== 8'h03) begin fails++; $display("FAIL beq_fwd_pc got %h exp 03", dbg_pc); end
        run(3);
        tests++; if (dbg_pc !== 8'h10) begin fails++; $display("FAIL j_pc got %h exp 10", dbg_pc); end
        run(7);
        tests++; if (dbg_pc !== 8'h12) begin fails++; $display("FAIL beq_nt_pc got %h exp 12", dbg_pc); end
        rd(1, v);
        tests++; if (v !== 8'h07) begin fails++; $display("FAIL j_r1 got %h exp 07", v); end
    endtask

    task automatic test_single_step();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd1);
        rom[1] = enc_i(6'b001000, 0, 2, 16'd2);
        rom[2] = enc_i(6'b001000, 0, 3, 16'd3);
        rom[3] = enc_i(6'b001000, 0, 4, 16'd4);
        do_reset(1'b0);
        run(10);
        tests++; if (dbg_pc !== 8'h00 || dbg_state !== 3'd0) begin fails++; $display("FAIL step_idle got pc %h st %0d exp pc 00 st 0", dbg_pc, dbg_state); end
        step_pulse();
        run(10);
        rd(1, v);
        tests++; if (v !== 8'h01 || dbg_pc !== 8'h01) begin fails++; $display("FAIL step_one got r1 %h pc %h exp r1 01 pc 01", v, dbg_pc); end
        rd(2, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL step_one_r2 got %h exp 00", v); end
        step_pulse();
        step_pulse();
        step_pulse();
        run(20);
        rd(3, v);
        tests++; if (v !== 8'h03) begin fails++; $display("FAIL step_extra_r3 got %h exp 03", v); end
        rd(4, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL step_sat_r4 got %h exp 00", v); end
        tests++; if (dbg_pc !== 8'h03 || dbg_state !== 3'd0) begin fails++; $display("FAIL step_end got pc %h st %0d exp pc 03 st 0", dbg_pc, dbg_state); end
    endtask

    task automatic test_halt();
        logic [7:0] v;
        int snap;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd9);
        rom[1] = 32'hFC000000;
        do_reset(1'b1);
        run(4);
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early got %b exp 0", halted); end
        run(2);
        tests++; if (halted !== 1'b1 || dbg_state !== 3'd7) begin fails++; $display("FAIL halt_op got h %b st %0d exp h 1 st 7", halted, dbg_state); end
        snap = we_cnt;
        run(10);
        rd(1, v);
        tests++; if (v !== 8'h09 || dbg_state !== 3'd7 || dbg_pc !== 8'h02) begin fails++; $display("FAIL halt_hold got r1 %h st %0d pc %h exp 09 7 02", v, dbg_state, dbg_pc); end
        tests++; if (we_cnt !== snap) begin fails++; $display("FAIL halt_we got %0d exp %0d", we_cnt, snap); end

        clear_rom();
        rom[0] = enc_r(1, 2, 3, 6'b000001);
        do_reset(1'b1);
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_cleared got %b exp 0", halted); end
        run(2);
        tests++; if (halted !== 1'b1 || dbg_state !== 3'd7) begin fails++; $display("FAIL halt_funct got h %b st %0d exp h 1 st 7", halted, dbg_state); end
    endtask

    task automatic test_reset_mid_mem();
        logic [7:0] v;
        clear_rom();
        rom[0] = enc_i(6'b001000, 0, 1, 16'd5);
        rom[1] = enc_i(6'b101011, 0, 1, 16'd3);
        do_reset(1'b1);
        ram[3] = 8'hAA;
        run(7);
        tests++; if (dmem_we !== 1'b1 || dbg_state !== 3'd3) begin fails++; $display("FAIL mem_before_rst got we %b st %0d exp we 1 st 3", dmem_we, dbg_state); end
        rst = 1'b1;
        #1;
        tests++; if (dmem_we !== 1'b0 || dbg_pc !== 8'h00 || dbg_state !== 3'd0) begin fails++; $display("FAIL rst_async got we %b pc %h st %0d exp 0 00 0", dmem_we, dbg_pc, dbg_state); end
        rd(1, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL rst_regs got %h exp 00", v); end
        run(2);
        tests++; if (ram[3] !== 8'hAA) begin fails++; $display("FAIL rst_no_store got %h exp aa", ram[3]); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_seq();
        test_alu_ops();
        test_load_store();
        test_branch_jump();
        test_single_step();
        test_halt();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
